// File: rtl/aes_inv_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_key_expand
// Purpose  : Reverse AES-128 key schedule; streams round keys N down to T.
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_key_expand #(
    parameter int MAX_ROUND = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    input  logic [3:0]   in_round,
    input  logic [3:0]   in_target,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         out_last,
    output logic         err
);

    localparam logic [3:0] C_MAX_ROUND = 4'(MAX_ROUND);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic         r_ready_en;
    logic         r_valid;
    logic         r_last;
    logic         r_err;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic [3:0]   r_target;

    logic         w_accept;
    logic         w_legal;
    logic         w_fire;
    logic [3:0]   w_round_dec;
    logic [31:0]  w_p0, w_p1, w_p2, w_p3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [127:0] w_prev_key;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, followed by the S-box affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign w_accept    = in_valid && in_ready;
    assign w_legal     = (in_round <= C_MAX_ROUND) && (in_target <= in_round);
    assign w_fire      = r_valid && out_ready;
    assign w_round_dec = r_round - 4'd1;

    // Undo one forward expansion step from the held key.
    assign w_p3 = r_key[31:0]  ^ r_key[63:32];
    assign w_p2 = r_key[63:32] ^ r_key[95:64];
    assign w_p1 = r_key[95:64] ^ r_key[127:96];
    assign w_rot = {w_p3[23:0], w_p3[31:24]};

    generate
        for (genvar j = 0; j < 4; j++) begin : g_sbox
            assign w_sub[8*j +: 8] = sbox(w_rot[8*j +: 8]);
        end
    endgenerate

    assign w_p0       = r_key[127:96] ^ w_sub ^ {rcon(r_round), 24'h000000};
    assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_legal) w_next = S_EMIT;
            S_EMIT:  if (w_fire && r_last)    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready_en <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
            r_key      <= '0;
            r_round    <= '0;
            r_target   <= '0;
        end else begin
            r_state    <= w_next;
            r_ready_en <= 1'b1;
            r_err      <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_key    <= in_key;
                r_round  <= in_round;
                r_target <= in_target;
                r_last   <= (in_round == in_target);
                r_valid  <= 1'b1;
            end else if (w_fire) begin
                if (r_last) begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end else begin
                    r_key   <= w_prev_key;
                    r_round <= w_round_dec;
                    r_last  <= (w_round_dec == r_target);
                end
            end
        end
    end

    assign in_ready  = r_ready_en && (r_state == S_IDLE);
    assign out_valid = r_valid;
    assign out_key   = r_key;
    assign out_round = r_round;
    assign out_last  = r_last;
    assign err       = r_err;

endmodule
`default_nettype wire
